// File: rtl/recebe_ascii_bcd.sv
// Serial 8O1 receiver that packs two consecutive ASCII decimal digits into one BCD byte {tens, units}.
// Optional pair timeout between tens and units digits is built when RECEBE_TIMEOUT_EN is defined.
module recebe_ascii_bcd #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 44
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] bcd,
    output logic       pronto_recepcao_bcd,
    output logic       erro_recepcao,
    output logic       recebendo
);

    localparam int T  = CLOCK_FREQ / BAUD_RATE;
    localparam int H  = T / 2;
    localparam int TW = $clog2(T + 1);
    localparam logic [TW-1:0] T_FIM = TW'(T - 1);
    localparam logic [TW-1:0] H_FIM = TW'(H - 1);

    generate
        if (T < 2 || TIMEOUT_BITS < 1) begin : g_param_check
            $error("recebe_ascii_bcd: bit period must be >= 2 clocks and TIMEOUT_BITS >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} estado_bit_t;
    typedef enum logic {ESPERA_DEZENA, ESPERA_UNIDADE} estado_dig_t;

    logic          rx_meta, rx_sinc;
    estado_bit_t   estado;
    estado_dig_t   dig;
    logic [TW-1:0] tick;
    logic [2:0]    nbit;
    logic [7:0]    dado;
    logic          par;
    logic [3:0]    dezena;
    logic          amostra_parada;
    logic          char_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sinc <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sinc <= rx_meta;
        end
    end

    // Bit-level framing: start is re-checked at mid-bit, then every bit is sampled one period later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            tick      <= '0;
            nbit      <= '0;
            dado      <= '0;
            par       <= 1'b0;
            recebendo <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    tick <= '0;
                    nbit <= '0;
                    if (!rx_sinc) begin
                        estado    <= INICIO;
                        recebendo <= 1'b1;
                    end
                end
                INICIO: begin
                    if (tick == H_FIM) begin
                        tick <= '0;
                        if (rx_sinc) begin
                            estado    <= OCIOSO;
                            recebendo <= 1'b0;
                        end else begin
                            estado <= DADOS;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                DADOS: begin
                    if (tick == T_FIM) begin
                        tick <= '0;
                        dado <= {rx_sinc, dado[7:1]};
                        nbit <= nbit + 3'd1;
                        if (nbit == 3'd7)
                            estado <= PARIDADE;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                PARIDADE: begin
                    if (tick == T_FIM) begin
                        tick   <= '0;
                        par    <= rx_sinc;
                        estado <= PARADA;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                PARADA: begin
                    if (tick == T_FIM) begin
                        tick      <= '0;
                        estado    <= OCIOSO;
                        recebendo <= 1'b0;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                default: begin
                    estado    <= OCIOSO;
                    recebendo <= 1'b0;
                end
            endcase
        end
    end

    // Validation uses the live stop sample so the pulses land in the cycle right after that edge.
    assign amostra_parada = (estado == PARADA) && (tick == T_FIM);
    assign char_ok = rx_sinc && (^{dado, par}) && (dado >= 8'h30) && (dado <= 8'h39);

`ifdef RECEBE_TIMEOUT_EN
    localparam int LIMITE = TIMEOUT_BITS * T;
    logic [31:0] cnt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dig                 <= ESPERA_DEZENA;
            dezena              <= '0;
            bcd                 <= '0;
            pronto_recepcao_bcd <= 1'b0;
            erro_recepcao       <= 1'b0;
`ifdef RECEBE_TIMEOUT_EN
            cnt                 <= '0;
`endif
        end else begin
            pronto_recepcao_bcd <= 1'b0;
            erro_recepcao       <= 1'b0;
            if (amostra_parada) begin
`ifdef RECEBE_TIMEOUT_EN
                cnt <= '0;
`endif
                if (!char_ok) begin
                    erro_recepcao <= 1'b1;
                    dig           <= ESPERA_DEZENA;
                end else if (dig == ESPERA_DEZENA) begin
                    dezena <= dado[3:0];
                    dig    <= ESPERA_UNIDADE;
                end else begin
                    bcd                 <= {dezena, dado[3:0]};
                    pronto_recepcao_bcd <= 1'b1;
                    dig                 <= ESPERA_DEZENA;
                end
            end
`ifdef RECEBE_TIMEOUT_EN
            // Pair timer pauses while a frame is on the wire.
            else if (dig == ESPERA_UNIDADE && !recebendo) begin
                if (cnt == 32'(LIMITE - 1)) begin
                    cnt           <= '0;
                    erro_recepcao <= 1'b1;
                    dig           <= ESPERA_DEZENA;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_recebe_ascii_bcd.sv
// Scoreboard bench for recebe_ascii_bcd: expected pulses are queued as frames are sent and checked by a monitor.
module tb_recebe_ascii_bcd;

    localparam int CLK_F = 50000000;
    localparam int BAUD  = 500000;
    localparam int T     = CLK_F / BAUD;
    localparam int TOUT  = 44;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_serial;
    logic [7:0] bcd;
    logic       pronto_recepcao_bcd;
    logic       erro_recepcao;
    logic       recebendo;

    typedef struct {
        bit         eh_erro;
        logic [7:0] val;
    } esperado_t;

    esperado_t fila[$];
    int total = 0;
    int bad   = 0;

    always #10 clock = ~clock;

    recebe_ascii_bcd #(
        .CLOCK_FREQ(CLK_F),
        .BAUD_RATE(BAUD),
        .TIMEOUT_BITS(TOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_serial(rx_serial),
        .bcd(bcd),
        .pronto_recepcao_bcd(pronto_recepcao_bcd),
        .erro_recepcao(erro_recepcao),
        .recebendo(recebendo)
    );

    // Every output pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (pronto_recepcao_bcd === 1'b1 && erro_recepcao === 1'b1) begin
                total++;
                bad++;
                $display("FAIL pulse_overlap: got pronto=1 erro=1, need at most one high");
            end else if (pronto_recepcao_bcd === 1'b1 || erro_recepcao === 1'b1) begin
                total++;
                if (fila.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got pronto=%0b erro=%0b bcd=%h, need no pulse",
                             pronto_recepcao_bcd, erro_recepcao, bcd);
                end else begin
                    esperado_t e;
                    e = fila.pop_front();
                    if (erro_recepcao !== e.eh_erro || (!e.eh_erro && bcd !== e.val)) begin
                        bad++;
                        $display("FAIL pulse: got erro=%0b bcd=%h, need erro=%0b bcd=%h",
                                 erro_recepcao, bcd, e.eh_erro, e.val);
                    end
                end
            end
        end
    end

    task automatic espera(input bit eh_erro, input logic [7:0] v);
        esperado_t e;
        e.eh_erro = eh_erro;
        e.val     = v;
        fila.push_back(e);
    endtask

    task automatic ocioso(input int n);
        @(negedge clock) rx_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
        logic p;
        p = ~^b;
        if (!par_ok) p = ~p;
        @(negedge clock) rx_serial = 1'b0;
        repeat (T) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (T) @(negedge clock);
        end
        rx_serial = p;
        repeat (T) @(negedge clock);
        rx_serial = stop;
        repeat (T) @(negedge clock);
    endtask

    task automatic send_digit(input logic [7:0] c);
        send_frame(c, 1'b1, 1'b1);
    endtask

    task automatic drain(input string nome);
        int n;
        n = 0;
        while (fila.size() != 0 && n < 4 * T) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (fila.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending pulses, need 0", nome, fila.size());
            fila.delete();
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({bcd, pronto_recepcao_bcd, erro_recepcao, recebendo} !== 11'h0) begin
            bad++;
            $display("FAIL reset_state: got bcd=%h pronto=%0b erro=%0b rec=%0b, need all 0",
                     bcd, pronto_recepcao_bcd, erro_recepcao, recebendo);
        end
        reset = 1'b0;
        ocioso(T);
    endtask

    task automatic test_pair;
        espera(1'b0, 8'h47);
        send_digit(8'h34);
        send_digit(8'h37);
        drain("pair_47");
    endtask

    task automatic test_parity;
        espera(1'b1, 8'h00);
        send_frame(8'h35, 1'b0, 1'b1);
        espera(1'b0, 8'h12);
        send_digit(8'h31);
        send_digit(8'h32);
        drain("parity_then_12");
    endtask

    task automatic test_char_error;
        espera(1'b1, 8'h00);
        send_digit(8'h33);
        send_digit(8'h41);
        drain("char_A");
        total++;
        if (bcd !== 8'h12) begin
            bad++;
            $display("FAIL bcd_hold: got %h, need 12", bcd);
        end
        espera(1'b0, 8'h90);
        send_digit(8'h39);
        send_digit(8'h30);
        drain("pair_90");
    endtask

    task automatic test_stop;
        espera(1'b1, 8'h00);
        send_frame(8'h38, 1'b1, 1'b0);
        ocioso(2 * T);
        espera(1'b0, 8'h25);
        send_digit(8'h32);
        send_digit(8'h35);
        drain("stop_then_25");
    endtask

    task automatic test_glitch;
        bit viu;
        viu = 1'b0;
        @(negedge clock) rx_serial = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (recebendo === 1'b1) viu = 1'b1;
        end
        rx_serial = 1'b1;
        repeat (3 * T) begin
            @(negedge clock);
            if (recebendo === 1'b1) viu = 1'b1;
        end
        total++;
        if (viu !== 1'b1 || recebendo !== 1'b0) begin
            bad++;
            $display("FAIL glitch_recebendo: got seen_high=%0b final=%0b, need 1 and 0", viu, recebendo);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        b = 8'h36;
        send_digit(8'h39);
        @(negedge clock) rx_serial = 1'b0;
        repeat (T) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx_serial = b[i];
            repeat (T) @(negedge clock);
        end
        rx_serial = b[4];
        repeat (T / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({bcd, pronto_recepcao_bcd, erro_recepcao, recebendo} !== 11'h0) begin
            bad++;
            $display("FAIL reset_mid: got bcd=%h pronto=%0b erro=%0b rec=%0b, need all 0",
                     bcd, pronto_recepcao_bcd, erro_recepcao, recebendo);
        end
        rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        ocioso(T);
        espera(1'b0, 8'h61);
        send_digit(8'h36);
        send_digit(8'h31);
        drain("after_reset_61");
    endtask

    task automatic test_timeout;
`ifdef RECEBE_TIMEOUT_EN
        espera(1'b1, 8'h00);
`endif
        send_digit(8'h37);
        ocioso(TOUT * T + 10);
`ifdef RECEBE_TIMEOUT_EN
        espera(1'b0, 8'h33);
        send_digit(8'h33);
        send_digit(8'h33);
`else
        espera(1'b0, 8'h73);
        send_digit(8'h33);
        send_digit(8'h33);
        espera(1'b0, 8'h35);
        send_digit(8'h35);
`endif
        drain("timeout");
    endtask

    initial begin
        test_reset;
        test_pair;
        test_parity;
        test_char_error;
        test_stop;
        test_glitch;
        test_reset_mid;
        test_timeout;
        ocioso(T);
        total++;
        if (fila.size() != 0) begin
            bad++;
            $display("FAIL final_queue: got %0d pending, need 0", fila.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recebe_ascii_bcd.md
Name: recebe_ascii_bcd

Overview:
- Receive direction of the BCD-over-serial link: deserialises 8O1 frames on rx_serial (8 data bits LSB first, odd parity, 1 stop bit) at BAUD_RATE.
- Accepts ASCII decimal digits '0'..'9' (0x30..0x39) and packs two consecutive digits into one BCD byte: first digit is the tens nibble, second is the units.
- Sits at the serial input of the datapath. It mirrors the transmitter, which sends the tens digit first.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. Bit period T = CLOCK_FREQ/BAUD_RATE using integer division (434 at the defaults). Half period H = T/2 (217).
- TIMEOUT_BITS, 44, number of bit periods allowed between the two digits of a pair. Used only with TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_serial  in  1  serial line; idle high.
- bcd  out  8  last complete packed BCD pair, {tens, units}.
- pronto_recepcao_bcd  out  1  one-cycle pulse when bcd is updated.
- erro_recepcao  out  1  one-cycle pulse on any frame or character error.
- recebendo  out  1  high while a frame is in progress, from start detection to the end of the stop sample.

Behaviour:
- Reset values: bcd=0x00, pronto_recepcao_bcd=0, erro_recepcao=0, recebendo=0. Internally: synchroniser flops=1, bit FSM=OCIOSO, digit FSM=ESPERA_DEZENA.
- Input path: rx_serial passes through a 2-flop synchroniser (reset value 1). All timing below refers to the synchronised signal.
- Bit FSM states: OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
- OCIOSO: a sampled 0 moves to INICIO, clears the tick counter and sets recebendo=1.
- INICIO: after H ticks, sample the line. If 0, go to DADOS. If 1, treat it as a glitch: return to OCIOSO, no error, recebendo=0.
- DADOS: sample every T ticks, 8 samples, shifted in LSB first.
- PARIDADE: one sample after T ticks. Parity is correct when the data ones plus the parity bit give an odd count.
- PARADA: one sample after T ticks. 1 = valid stop; 0 = framing error. Then return to OCIOSO with recebendo=0. The line does not need to return high before the next start: a 0 in OCIOSO starts a new frame.
- Character validation happens on the cycle after the stop sample. A character is valid only if the stop bit is 1, parity is correct and the byte is in 0x30..0x39.
- Digit FSM: ESPERA_DEZENA and ESPERA_UNIDADE.
  - ESPERA_DEZENA + valid char: latch byte[3:0] as tens, go to ESPERA_UNIDADE. No output pulse.
  - ESPERA_UNIDADE + valid char: bcd <= {tens, byte[3:0]}, pronto_recepcao_bcd=1 for one cycle, go to ESPERA_DEZENA.
  - Invalid char in either state: erro_recepcao=1 for one cycle, discard the pending tens digit, go to ESPERA_DEZENA, bcd unchanged.
- Latency: pronto/erro are asserted in the clock cycle immediately after the stop-bit sample edge. bcd changes on that same edge and holds until the next complete pair.
- pronto_recepcao_bcd and erro_recepcao are never high in the same cycle.
- Asserting reset mid-frame aborts the frame immediately. No pulse is emitted, and the pending digit is lost.

Optional Feature:
- Macro: RECEBE_TIMEOUT_EN.
- Defined: in ESPERA_UNIDADE a counter runs, counting TIMEOUT_BITS*T clocks from the tens-digit validation. It is frozen while recebendo=1. On expiry: discard the tens digit, return to ESPERA_DEZENA and pulse erro_recepcao for one cycle.
- Not defined: no counter is built, and ESPERA_UNIDADE waits indefinitely.

Test Plan:
- Send 0x34 ('4', parity bit 0) then 0x37 ('7', parity bit 0) at 434 clocks/bit -> exactly one pronto pulse after the second stop sample; bcd=0x47; erro never high.
- Send 0x35 with parity bit 0 (wrong; correct is 1), then '1', '2' -> one erro pulse after the first frame; then bcd=0x12 with one pronto pulse.
- Send '3' then 'A' (0x41, parity bit 1), then '9', '0' -> erro pulse on 'A', bcd still previous value; then bcd=0x90 with one pronto pulse.
- Send '8' with stop bit 0 -> erro pulse, digit FSM in ESPERA_DEZENA; a following '2','5' gives bcd=0x25.
- Drive rx_serial low for 100 clocks then high -> recebendo rises then falls, no pronto/erro. Separately, assert reset in the middle of data bit 4 -> all outputs 0 within the reset assertion, and a following '6','1' gives bcd=0x61.
- With RECEBE_TIMEOUT_EN: send '7', idle 44*434+10 clocks, then '3','3' -> erro pulse at expiry, then bcd=0x33. Without the macro, the same stimulus gives bcd=0x73 and a spare tens digit '3' pending.
